// File: rtl/divisibility_checker_seq_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Package    : div_pkg                                                   |
// | Description: Shared state encoding and parameter helpers for the       |
// |              sequential divisibility checker.                          |
// | Revision   : 1.0 - initial release                                     |
// +-----------------------------------------------------------------------+
package div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int rem_width(input int divisor);
        int w;
        w = $clog2(divisor);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic bit width_ok(input int data_w, input int bits_per_cyc);
        return (bits_per_cyc == 1 || bits_per_cyc == 2 || bits_per_cyc == 4 ||
                bits_per_cyc == 8) && (data_w > 0) && ((data_w % bits_per_cyc) == 0);
    endfunction

    function automatic bit divisor_ok(input int divisor);
        return divisor >= 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/divisibility_checker_seq_mod_step.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module     : div_mod_step                                              |
// | Description: One folding step: (rem_in*2^B + chunk) mod DIVISOR using  |
// |              a restoring compare/subtract chain.                       |
// | Revision   : 1.0 - initial release                                     |
// +-----------------------------------------------------------------------+
module div_mod_step
    import div_pkg::*;
#(
    parameter  int DIVISOR      = 3,
    parameter  int BITS_PER_CYC = 1,
    localparam int REM_W        = rem_width(DIVISOR)
) (
    input  logic [REM_W-1:0]        rem_in,
    input  logic [BITS_PER_CYC-1:0] chunk,
    output logic [REM_W-1:0]        rem_out
);

    localparam int                 c_sum_w = REM_W + BITS_PER_CYC;
    localparam logic [c_sum_w-1:0] c_div   = c_sum_w'(DIVISOR);

    logic [c_sum_w-1:0] w_stage [0:BITS_PER_CYC-1];

    assign w_stage[0] = {rem_in, chunk};

    // The sum is below DIVISOR*2^B, so subtracting DIVISOR*2^k for k = B-1..0
    // leaves a value below DIVISOR after the last stage.
    for (genvar k = 0; k < BITS_PER_CYC; k++) begin : g_stage
        localparam logic [c_sum_w-1:0] c_sub = c_div << (BITS_PER_CYC - 1 - k);
        if (k < BITS_PER_CYC - 1) begin : g_mid
            assign w_stage[k+1] = (w_stage[k] >= c_sub) ? (w_stage[k] - c_sub) : w_stage[k];
        end else begin : g_last
            assign rem_out = REM_W'((w_stage[k] >= c_sub) ? (w_stage[k] - c_sub) : w_stage[k]);
        end
    end

endmodule
`default_nettype wire

// File: rtl/divisibility_checker_seq.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module     : divisibility_checker_seq                                  |
// | Description: Sequential in_data mod DIVISOR, B bits per cycle MSB      |
// |              first, valid/ready on both sides. Optional macro          |
// |              DIV_BACK2BACK_EN overlaps result handshake with accept.   |
// | Revision   : 1.0 - initial release                                     |
// +-----------------------------------------------------------------------+
module divisibility_checker_seq
    import div_pkg::*;
#(
    parameter  int DATA_W       = 16,
    parameter  int DIVISOR      = 3,
    parameter  int BITS_PER_CYC = 1,
    localparam int REM_W        = rem_width(DIVISOR)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [REM_W-1:0]  out_remainder,
    output logic              out_divisible,
    output logic              busy
);

    localparam int c_n     = DATA_W / BITS_PER_CYC;
    localparam int c_cnt_w = $clog2(c_n + 1);

    if (!width_ok(DATA_W, BITS_PER_CYC)) begin : g_chk_width
        $error("DATA_W must be a multiple of BITS_PER_CYC (1, 2, 4 or 8)");
    end
    if (!divisor_ok(DIVISOR)) begin : g_chk_divisor
        $error("DIVISOR must be >= 1");
    end

    state_t                  r_state;
    state_t                  w_next_state;
    logic [DATA_W-1:0]       r_shift;
    logic [c_cnt_w-1:0]      r_cnt;
    logic [REM_W-1:0]        r_rem;
    logic [REM_W-1:0]        w_rem_next;
    logic [BITS_PER_CYC-1:0] w_chunk;
    logic                    w_accept;
    logic                    w_out_hs;

    assign w_accept = in_valid && in_ready;
    assign w_out_hs = out_valid && out_ready;
    assign w_chunk  = r_shift[DATA_W-1 -: BITS_PER_CYC];

    div_mod_step #(
        .DIVISOR      (DIVISOR),
        .BITS_PER_CYC (BITS_PER_CYC)
    ) u_step (
        .rem_in  (r_rem),
        .chunk   (w_chunk),
        .rem_out (w_rem_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // In the default build in_ready is low in DONE, so w_accept there can
    // only come from the back-to-back path.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_next_state = ST_RUN;
            ST_RUN:  if (r_cnt == c_cnt_w'(1)) w_next_state = ST_DONE;
            ST_DONE: if (w_out_hs) w_next_state = w_accept ? ST_RUN : ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready      = 1'b0;
        out_valid     = 1'b0;
        busy          = 1'b1;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            ST_DONE: begin
                out_valid = 1'b1;
`ifdef DIV_BACK2BACK_EN
                in_ready  = out_ready;
`endif
            end
            default: ;
        endcase
        out_remainder = r_rem;
        out_divisible = out_valid && (r_rem == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_rem   <= '0;
        end else if (w_accept) begin
            r_shift <= in_data;
            r_cnt   <= c_cnt_w'(c_n);
            r_rem   <= '0;
        end else if (r_state == ST_RUN) begin
            r_shift <= r_shift << BITS_PER_CYC;
            r_cnt   <= r_cnt - c_cnt_w'(1);
            r_rem   <= w_rem_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_divisibility_checker_seq.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module     : tb_divisibility_checker_seq                               |
// | Description: Directed and randomised scoreboard bench for the          |
// |              sequential divisibility checker.                          |
// | Revision   : 1.0 - initial release                                     |
// +-----------------------------------------------------------------------+
module tb_divisibility_checker_seq;

    localparam int NW  = 1000;
    localparam int TMO = 200;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // directed instances: 16/3/1 and 16/7/4
    logic        d_rst = 1'b1;
    logic        d_in_valid, d_in_ready, d_out_valid, d_out_ready, d_div, d_busy;
    logic [15:0] d_in_data;
    logic [1:0]  d_rem;
    logic        e_in_valid, e_in_ready, e_out_valid, e_out_ready, e_div, e_busy;
    logic [15:0] e_in_data;
    logic [2:0]  e_rem;

    divisibility_checker_seq #(.DATA_W(16), .DIVISOR(3), .BITS_PER_CYC(1)) u_dir (
        .clk(clk), .rst(d_rst), .in_valid(d_in_valid), .in_ready(d_in_ready),
        .in_data(d_in_data), .out_valid(d_out_valid), .out_ready(d_out_ready),
        .out_remainder(d_rem), .out_divisible(d_div), .busy(d_busy));

    divisibility_checker_seq #(.DATA_W(16), .DIVISOR(7), .BITS_PER_CYC(4)) u_d7 (
        .clk(clk), .rst(d_rst), .in_valid(e_in_valid), .in_ready(e_in_ready),
        .in_data(e_in_data), .out_valid(e_out_valid), .out_ready(e_out_ready),
        .out_remainder(e_rem), .out_divisible(e_div), .busy(e_busy));

    task automatic dir_word(input logic [15:0] data, input int exp_rem, input string tag);
        int lat;
        d_in_valid = 1'b1;
        d_in_data  = data;
        @(negedge clk);
        check({tag, "_in_ready"}, d_in_ready, 1);
        @(posedge clk); #1;
        d_in_valid = 1'b0;
        lat = 0;
        while (!d_out_valid && lat < TMO) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, lat, 16);
        check({tag, "_rem"}, d_rem, exp_rem);
        check({tag, "_div"}, d_div, (exp_rem == 0) ? 1 : 0);
        d_out_ready = 1'b1;
        @(posedge clk); #1;
        d_out_ready = 1'b0;
        check({tag, "_idle"}, d_busy, 0);
    endtask

    // randomised scoreboard instances
    localparam int c_divs [5] = '{1, 3, 5, 7, 10};
    localparam int c_bits [3] = '{1, 2, 4};
    logic r_rst = 1'b1;
    int   rnd_done = 0;

    for (genvar gi = 0; gi < 5; gi++) begin : g_div
        for (genvar gj = 0; gj < 3; gj++) begin : g_bpc
            localparam int D  = c_divs[gi];
            localparam int B  = c_bits[gj];
            localparam int RW = div_pkg::rem_width(D);
            logic          iv, ir, ov, orr, dv, bz;
            logic [15:0]   id;
            logic [RW-1:0] rm;
            int            exp_q[$];
            int            e_v;

            divisibility_checker_seq #(.DATA_W(16), .DIVISOR(D), .BITS_PER_CYC(B)) u_dut (
                .clk(clk), .rst(r_rst), .in_valid(iv), .in_ready(ir), .in_data(id),
                .out_valid(ov), .out_ready(orr), .out_remainder(rm), .out_divisible(dv),
                .busy(bz));

            initial begin : p_drive
                int t;
                int sel;
                iv = 1'b0;
                id = '0;
                wait (r_rst == 1'b0);
                @(posedge clk); #1;
                for (int n = 0; n < NW; n++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk); #1;
                    end
                    sel = $urandom_range(0, 15);
                    id  = (sel == 0) ? 16'h0000 : (sel == 1) ? 16'hFFFF : 16'($urandom);
                    iv  = 1'b1;
                    t   = 0;
                    @(negedge clk);
                    while (!ir && t < TMO) begin
                        @(negedge clk);
                        t++;
                    end
                    check($sformatf("rnd_accept_d%0d_b%0d", D, B), (t < TMO) ? 1 : 0, 1);
                    if (t < TMO) exp_q.push_back(int'(id) % D);
                    @(posedge clk); #1;
                    iv = 1'b0;
                end
                t = 0;
                while (exp_q.size() != 0 && t < 1000) begin
                    @(posedge clk);
                    t++;
                end
                check($sformatf("rnd_drain_d%0d_b%0d", D, B), exp_q.size(), 0);
                rnd_done++;
            end

            initial begin : p_ready
                orr = 1'b0;
                forever begin
                    @(posedge clk); #1;
                    orr = ($urandom_range(0, 3) != 0);
                end
            end

            always @(negedge clk) begin
                if (ov && orr) begin
                    if (exp_q.size() == 0) begin
                        check($sformatf("rnd_unexpected_d%0d_b%0d", D, B), 1, 0);
                    end else begin
                        e_v = exp_q.pop_front();
                        check($sformatf("rnd_rem_d%0d_b%0d", D, B), rm, e_v);
                        check($sformatf("rnd_div_d%0d_b%0d", D, B), dv, (e_v == 0) ? 1 : 0);
                    end
                end
            end
        end
    end

    initial begin : p_main
        int lat;
        int n;
        int t;
        int acc [2];
        bit saw;
        d_in_valid = 1'b0; d_in_data = '0; d_out_ready = 1'b0;
        e_in_valid = 1'b0; e_in_data = '0; e_out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        d_rst = 1'b0;
        r_rst = 1'b0;

        check("reset_in_ready", d_in_ready, 1);
        check("reset_out_valid", d_out_valid, 0);
        check("reset_rem", d_rem, 0);
        check("reset_div", d_div, 0);
        check("reset_busy", d_busy, 0);

        dir_word(16'h0003, 0, "w0003");
        dir_word(16'h0007, 1, "w0007");
        dir_word(16'hFFFE, 2, "wFFFE");
        dir_word(16'hFFFF, 0, "wFFFF");

        // backpressure in DONE with a competing word offered
        d_in_valid = 1'b1; d_in_data = 16'h0007;
        @(posedge clk); #1;
        d_in_valid = 1'b0;
        lat = 0;
        while (!d_out_valid && lat < TMO) begin
            @(posedge clk); #1;
            lat++;
        end
        d_in_valid = 1'b1; d_in_data = 16'h0005;
        repeat (5) begin
            @(posedge clk); #1;
            check("bp_valid", d_out_valid, 1);
            check("bp_rem", d_rem, 1);
            check("bp_in_ready", d_in_ready, 0);
        end
        d_in_valid  = 1'b0;
        d_out_ready = 1'b1;
        @(posedge clk); #1;
        d_out_ready = 1'b0;
        check("bp_release_busy", d_busy, 0);
        check("bp_release_valid", d_out_valid, 0);
        repeat (3) @(posedge clk);
        #1;
        check("bp_second_not_taken", d_busy, 0);

        // reset 7 cycles into RUN
        d_in_valid = 1'b1; d_in_data = 16'h1234;
        @(posedge clk); #1;
        d_in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        d_rst = 1'b1;
        #2;
        check("rst_async_busy", d_busy, 0);
        @(posedge clk); #1;
        d_rst = 1'b0;
        check("rst_in_ready", d_in_ready, 1);
        saw = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (d_out_valid) saw = 1'b1;
        end
        check("rst_no_valid", saw, 0);
        dir_word(16'h0009, 0, "w0009");

        // DIVISOR=7, B=4
        e_in_valid = 1'b1; e_in_data = 16'd1000;
        @(posedge clk); #1;
        e_in_valid = 1'b0;
        lat = 0;
        while (!e_out_valid && lat < TMO) begin
            @(posedge clk); #1;
            lat++;
        end
        check("d7_latency", lat, 4);
        check("d7_rem", e_rem, 6);
        check("d7_div", e_div, 0);
        e_out_ready = 1'b1;
        @(posedge clk); #1;

        // accept spacing with a continuously offered stream
        e_in_valid = 1'b1; e_in_data = 16'd100;
        n = 0; t = 0;
        while (n < 2 && t < TMO) begin
            @(negedge clk);
            if (e_in_valid && e_in_ready) begin
                acc[n] = cyc;
                n++;
            end
            @(posedge clk); #1;
            t++;
            if (n == 1) e_in_data = 16'd200;
        end
        e_in_valid = 1'b0;
        check("tput_accepts", n, 2);
`ifdef DIV_BACK2BACK_EN
        check("tput_gap", acc[1] - acc[0], 5);
`else
        check("tput_gap", acc[1] - acc[0], 6);
`endif
        repeat (10) @(posedge clk);

        t = 0;
        while (rnd_done < 15 && t < 60000) begin
            @(posedge clk);
            t++;
        end
        check("rnd_complete", rnd_done, 15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
